// File: rtl/tx_pkg.sv
// Shared types and default sizes for the transmit path (trigger controller and burst generator).
package tx_pkg;

    localparam int HPER_W_DEF = 10;
    localparam int NCYC_W_DEF = 5;
    localparam int DEAD_T_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        PHP,
        PHN,
        DEAD
    } tx_state_t;

endpackage

// File: rtl/tx_burst_gen_if.sv
// Trigger-side bus of the burst generator: request with burst shape in, drive phases and status out.
interface tx_burst_gen_if
    import tx_pkg::*;
#(
    parameter int HPER_W = HPER_W_DEF,
    parameter int NCYC_W = NCYC_W_DEF
) ();

    logic              txtrigger;
    logic [HPER_W-1:0] HPER;
    logic [NCYC_W-1:0] NCYC;
    logic              txp;
    logic              txn;
    logic              busy;
    logic              done;

    modport master (
        output txtrigger, HPER, NCYC,
        input  txp, txn, busy, done
    );

    modport slave (
        input  txtrigger, HPER, NCYC,
        output txp, txn, busy, done
    );

endinterface

// File: rtl/tx_phase_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module tx_phase_timer #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/tx_burst_gen.sv
// Differential square-wave burst generator: one burst of NCYC periods (HPER clocks per half) per trigger.
// Define TX_DEADTIME_EN to insert DEAD_T idle clocks between phase changes.
module tx_burst_gen
    import tx_pkg::*;
#(
    parameter int HPER_W = HPER_W_DEF,
    parameter int NCYC_W = NCYC_W_DEF,
    parameter int DEAD_T = DEAD_T_DEF
) (
    input  logic          clock,
    input  logic          reset,
    tx_burst_gen_if.slave bus
);

    if (DEAD_T < 1) begin : g_bad_dead_t
        $error("tx_burst_gen: DEAD_T must be at least 1");
    end

    tx_state_t         state, state_d;
    logic [HPER_W-1:0] hper_q;
    logic [NCYC_W-1:0] ncyc_q;
    logic [NCYC_W-1:0] cyc_cnt;

    logic              accept;
    logic              latch;
    logic              cyc_clr;
    logic              cyc_inc;
    logic              ph_load;
    logic              ph_en;
    logic              ph_exp;
    logic [HPER_W-1:0] ph_val;

    logic              txp_q, txn_q, busy_q, done_q;

`ifdef TX_DEADTIME_EN
    tx_state_t         after_q, after_d;
    logic              dt_load;
    logic              dt_en;
    logic              dt_exp;
`endif

    // The done cycle still blocks a new trigger, so the earliest accept is the clock after done.
    assign accept = bus.txtrigger && (bus.HPER != '0) && (bus.NCYC != '0) && !done_q;

    tx_phase_timer #(.W(HPER_W)) u_phase_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (ph_load),
        .load_val (ph_val),
        .en       (ph_en),
        .expired  (ph_exp)
    );

`ifdef TX_DEADTIME_EN
    tx_phase_timer #(.W(HPER_W)) u_dead_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (dt_load),
        .load_val (HPER_W'(DEAD_T - 1)),
        .en       (dt_en),
        .expired  (dt_exp)
    );
`endif

    always_comb begin
        state_d = state;
        latch   = 1'b0;
        cyc_clr = 1'b0;
        cyc_inc = 1'b0;
        ph_load = 1'b0;
        ph_en   = 1'b0;
        ph_val  = hper_q - HPER_W'(1);
`ifdef TX_DEADTIME_EN
        after_d = after_q;
        dt_load = 1'b0;
        dt_en   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = PHP;
                    latch   = 1'b1;
                    cyc_clr = 1'b1;
                    ph_load = 1'b1;
                    ph_val  = bus.HPER - HPER_W'(1);
                end
            end
            PHP: begin
                if (ph_exp) begin
`ifdef TX_DEADTIME_EN
                    state_d = DEAD;
                    after_d = PHN;
                    dt_load = 1'b1;
`else
                    state_d = PHN;
                    ph_load = 1'b1;
`endif
                end else begin
                    ph_en = 1'b1;
                end
            end
            PHN: begin
                if (ph_exp) begin
                    // Comparing against NCYC-1 keeps the counter from wrapping at the maximum NCYC.
                    if (cyc_cnt == (ncyc_q - NCYC_W'(1))) begin
                        state_d = IDLE;
                    end else begin
                        cyc_inc = 1'b1;
`ifdef TX_DEADTIME_EN
                        state_d = DEAD;
                        after_d = PHP;
                        dt_load = 1'b1;
`else
                        state_d = PHP;
                        ph_load = 1'b1;
`endif
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end
            DEAD: begin
`ifdef TX_DEADTIME_EN
                if (dt_exp) begin
                    state_d = after_q;
                    ph_load = 1'b1;
                end else begin
                    dt_en = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            txp_q  <= 1'b0;
            txn_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            txp_q  <= (state_d == PHP);
            txn_q  <= (state_d == PHN);
            busy_q <= (state_d != IDLE);
            done_q <= (state != IDLE) && (state_d == IDLE);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hper_q  <= '0;
            ncyc_q  <= '0;
            cyc_cnt <= '0;
        end else begin
            if (latch) begin
                hper_q <= bus.HPER;
                ncyc_q <= bus.NCYC;
            end
            if (cyc_clr) begin
                cyc_cnt <= '0;
            end else if (cyc_inc) begin
                cyc_cnt <= cyc_cnt + NCYC_W'(1);
            end
        end
    end

`ifdef TX_DEADTIME_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            after_q <= PHP;
        end else begin
            after_q <= after_d;
        end
    end
`endif

    assign bus.txp  = txp_q;
    assign bus.txn  = txn_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_tx_burst_gen.sv
// Scoreboard bench for tx_burst_gen: accepted triggers queue an expected burst shape,
// a negedge monitor checks every burst cycle and pops the entry on done. Honours TX_DEADTIME_EN.
module tb_tx_burst_gen;

    localparam int HW = 10;
    localparam int NW = 5;
`ifdef TX_DEADTIME_EN
    localparam int DT = 2;
`else
    localparam int DT = 0;
`endif

    typedef struct {
        int h;
        int n;
    } burst_t;

    logic clock;
    logic reset;

    tx_burst_gen_if #(.HPER_W(HW), .NCYC_W(NW)) bus ();

    tx_burst_gen #(.HPER_W(HW), .NCYC_W(NW), .DEAD_T(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    burst_t exp_q[$];
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     exp_dones    = 0;
    int     done_cnt     = 0;
    int     overlap_cnt  = 0;
    int     idle_drive   = 0;
    bit     in_burst     = 0;
    int     idx          = 0;
    int     wave_err     = 0;
    burst_t cur;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [1:0] expPhase(input int h, input int n, input int i);
        int pos;
        pos = i;
        for (int ph = 0; ph < 2 * n; ph++) begin
            if (pos < h) return (ph % 2 == 0) ? 2'b10 : 2'b01;
            pos -= h;
            if (ph != 2 * n - 1) begin
                if (pos < DT) return 2'b00;
                pos -= DT;
            end
        end
        return 2'b00;
    endfunction

    // One-clock trigger pulse; accepted bursts are queued with the shape seen at the trigger edge.
    task automatic applyStimulus(input int h, input int n, input bit acc);
        burst_t b;
        @(negedge clock);
        bus.HPER      = HW'(h);
        bus.NCYC      = NW'(n);
        bus.txtrigger = 1'b1;
        if (acc) begin
            b.h = h;
            b.n = n;
            exp_q.push_back(b);
            exp_dones++;
        end
        @(negedge clock);
        bus.txtrigger = 1'b0;
        bus.HPER      = HW'($urandom_range(1, 9));
        bus.NCYC      = NW'($urandom_range(1, 9));
    endtask

    task automatic waitDone(input int maxc);
        int n;
        n = 0;
        while (!bus.done && n < maxc) begin
            @(negedge clock);
            n++;
        end
        if (!bus.done) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic expectQuiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clock);
            seen |= int'(bus.busy) | int'(bus.done);
        end
        checkOutput(tag, seen, 0);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            in_burst = 0;
            idx      = 0;
            wave_err = 0;
        end else begin
            if (bus.txp && bus.txn) overlap_cnt++;
            if (bus.busy) begin
                if (!in_burst) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_burst", 1, 0);
                        cur.h = 0;
                        cur.n = 0;
                    end else begin
                        cur = exp_q[0];
                    end
                    in_burst = 1;
                    idx      = 0;
                    wave_err = 0;
                end
                if ({bus.txp, bus.txn} != expPhase(cur.h, cur.n, idx)) wave_err++;
                idx++;
            end else if (bus.txp || bus.txn) begin
                idle_drive++;
            end
            if (bus.done) begin
                done_cnt++;
                checkOutput("done_busy_low", int'(bus.busy), 0);
                if (!in_burst) begin
                    checkOutput("done_without_burst", 0, 1);
                end else begin
                    checkOutput("busy_len", idx, 2 * cur.h * cur.n + DT * (2 * cur.n - 1));
                    checkOutput("wave_err", wave_err, 0);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    in_burst = 0;
                end
            end else if (!bus.busy && in_burst) begin
                checkOutput("missing_done", 0, 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                in_burst = 0;
            end
        end
    end

    initial begin
        reset         = 1'b0;
        bus.txtrigger = 1'b0;
        bus.HPER      = '0;
        bus.NCYC      = '0;
        #3;
        checkOutput("rst_txp", int'(bus.txp), 0);
        checkOutput("rst_txn", int'(bus.txn), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Reset mid-burst kills the outputs asynchronously and never yields done.
        applyStimulus(4, 3, 1);
        exp_dones--;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_txp", int'(bus.txp), 0);
        checkOutput("midrst_txn", int'(bus.txn), 0);
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_done", int'(bus.done), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        expectQuiet("post_rst_quiet", 3);
        applyStimulus(4, 3, 1);
        waitDone(200);

        applyStimulus(5, 3, 1);
        waitDone(200);
        applyStimulus(1, 1, 1);
        waitDone(50);

        applyStimulus(0, 3, 0);
        expectQuiet("zero_hper", 6);
        applyStimulus(4, 0, 0);
        expectQuiet("zero_ncyc", 6);

        // Triggers mid-burst and in the done cycle are dropped.
        applyStimulus(2, 2, 1);
        @(negedge clock);
        bus.HPER      = HW'(3);
        bus.NCYC      = NW'(1);
        bus.txtrigger = 1'b1;
        @(negedge clock);
        bus.txtrigger = 1'b0;
        waitDone(100);
        bus.HPER      = HW'(3);
        bus.NCYC      = NW'(1);
        bus.txtrigger = 1'b1;
        @(negedge clock);
        bus.txtrigger = 1'b0;
        expectQuiet("done_cycle_trig", 5);

        // A trigger one clock after done starts the next burst.
        applyStimulus(2, 1, 1);
        waitDone(100);
        applyStimulus(3, 2, 1);
        waitDone(100);

        applyStimulus(1, 31, 1);
        waitDone(400);
        applyStimulus(7, 2, 1);
        waitDone(200);

        repeat (4) @(negedge clock);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("done_count", done_cnt, exp_dones);
        checkOutput("txp_txn_overlap", overlap_cnt, 0);
        checkOutput("idle_drive", idle_drive, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
